// File: rtl/alu_md_pkg.sv
// -----------------------------------------------------------------------------
// alu_md_pkg
// Shared definitions for the RV32M multiply/divide sequencer: one-hot ALU
// opcodes, RV32M funct3 encodings, the sequencer state enum, the iteration
// count and small funct3/state decode helpers.
// -----------------------------------------------------------------------------
package alu_md_pkg;

    // Number of shift-add / restoring-division iterations (one per bit).
    localparam int unsigned ITER_N = 32;

    // One-hot ALU opcodes understood by the shared execute-stage ALU.
    // NOP makes the ALU pass operand B straight through to its result.
    localparam logic [9:0] OP_NOP  = 10'h000;
    localparam logic [9:0] OP_ADD  = 10'h001;
    localparam logic [9:0] OP_SUB  = 10'h002;
    localparam logic [9:0] OP_SLTU = 10'h010;

    // RV32M funct3 encodings handled here.
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_NEGA = 3'd2,
        ST_NEGB = 3'd3,
        ST_DIV  = 3'd4,
        ST_FIX  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // MUL and the four divide/remainder encodings are the only legal ones.
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_MUL) || f3[2];
    endfunction

    // DIV and REM treat their operands as two's complement.
    function automatic logic f3_signed(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

    // REM/REMU return the remainder rather than the quotient.
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // States in which the sequencer owns the shared ALU.
    function automatic logic owns_alu(input state_e s);
        return (s == ST_MUL) || (s == ST_NEGA) || (s == ST_NEGB) ||
               (s == ST_DIV) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/alu_md_seq.sv
// -----------------------------------------------------------------------------
// alu_md_seq
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer that borrows the shared
// combinational ALU of the execute stage. Multiplication is 32 shift-add steps;
// division takes absolute values, runs 32 restoring-division steps and then
// fixes the sign of the selected quotient/remainder. Division by zero, signed
// overflow and illegal funct3 complete immediately without touching the ALU.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start, funct3      request (accepted only in IDLE) and RV32M operation
//   rs1, rs2           dividend/multiplicand, divisor/multiplier
//   busy, done, err    handshake: busy cycle after accept through DONE,
//                      one-cycle done pulse, err with done on illegal funct3
//   result             held from done until overwritten by a later operation
//   alu_own            core ALU input mux selects alu_a/alu_b/alu_op when high
//   alu_a, alu_b,      ALU operands and one-hot opcode
//   alu_op
//   alu_c, alu_cf      ALU result and unsigned(A) < unsigned(B) flag, used in
//                      the same cycle they are produced
// -----------------------------------------------------------------------------
module alu_md_seq #(
    parameter int XLEN = 32,
    parameter int OPW  = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_c,
    input  logic            alu_cf
);

    import alu_md_pkg::*;

    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST_CNT = 5'(ITER_N - 1);

    state_e          state_r;
    state_e          state_nx_s;
    logic [2:0]      f3_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] dvd_r;
    logic [XLEN-1:0] dvs_r;
    // Partial remainder: its top bit is always zero after a step, so only the
    // low word is stored and the 33rd bit is rebuilt from the shift in rs_s.
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] q_r;
    logic [4:0]      cnt_r;
    logic [XLEN-1:0] result_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            own_r;

    logic            legal_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_res_s;
    logic [XLEN:0]   rs_s;
    logic            q_bit_s;
    logic [XLEN-1:0] sel_s;
    logic            neg_s;
    logic            last_s;
    logic [XLEN-1:0] alu_a_s;
    logic [XLEN-1:0] alu_b_s;
    logic [OPW-1:0]  alu_op_s;

    // Request decode: legality, early-out cases and their immediate result.
    always_comb begin
        legal_s    = f3_legal(funct3);
        fast_res_s = ZERO_W;
        fast_s     = 1'b0;
        if (!legal_s) begin
            fast_s     = 1'b1;
            fast_res_s = ZERO_W;
        end else if (funct3 == F3_MUL) begin
            fast_s     = 1'b0;
            fast_res_s = ZERO_W;
        end else if (rs2 == ZERO_W) begin
            fast_s     = 1'b1;
            fast_res_s = f3_is_rem(funct3) ? rs1 : ONES_W;
        end else if (f3_signed(funct3) && (rs1 == INT_MIN) && (rs2 == ONES_W)) begin
            fast_s     = 1'b1;
            fast_res_s = f3_is_rem(funct3) ? ZERO_W : INT_MIN;
        end else begin
            fast_s     = 1'b0;
            fast_res_s = ZERO_W;
        end
    end

    // Datapath helpers: shifted remainder, quotient bit and sign fix-up select.
    always_comb begin
        last_s  = (cnt_r == LAST_CNT);
        rs_s    = {rem_r, dvd_r[XLEN-1]};
        // Subtract succeeds when the shifted remainder overflowed 32 bits or
        // is not below the divisor.
        q_bit_s = rs_s[XLEN] | ~alu_cf;
        sel_s   = f3_is_rem(f3_r) ? rem_r : q_r;
        if (f3_is_rem(f3_r)) begin
            neg_s = f3_signed(f3_r) & a_r[XLEN-1];
        end else begin
            neg_s = f3_signed(f3_r) & (a_r[XLEN-1] ^ b_r[XLEN-1]);
        end
    end

    // ALU operand/opcode decode from the registered state.
    always_comb begin
        alu_a_s  = ZERO_W;
        alu_b_s  = ZERO_W;
        alu_op_s = OP_NOP;
        case (state_r)
            ST_MUL: begin
                alu_a_s  = acc_r;
                alu_b_s  = mcand_r;
                alu_op_s = mplier_r[0] ? OP_ADD : OP_NOP;
            end
            ST_NEGA: begin
                alu_b_s  = a_r;
                alu_op_s = (f3_signed(f3_r) && a_r[XLEN-1]) ? OP_SUB : OP_NOP;
            end
            ST_NEGB: begin
                alu_b_s  = b_r;
                alu_op_s = (f3_signed(f3_r) && b_r[XLEN-1]) ? OP_SUB : OP_NOP;
            end
            ST_DIV: begin
                alu_a_s  = rs_s[XLEN-1:0];
                alu_b_s  = dvs_r;
                alu_op_s = OP_SUB;
            end
            ST_FIX: begin
                alu_b_s  = sel_s;
                alu_op_s = neg_s ? OP_SUB : OP_NOP;
            end
            default: begin
                alu_a_s  = ZERO_W;
                alu_b_s  = ZERO_W;
                alu_op_s = OP_NOP;
            end
        endcase
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_nx_s = ST_IDLE;
                end else if (fast_s) begin
                    state_nx_s = ST_DONE;
                end else if (funct3 == F3_MUL) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_NEGA;
                end
            end
            ST_MUL:  state_nx_s = last_s ? ST_DONE : ST_MUL;
            ST_NEGA: state_nx_s = ST_NEGB;
            ST_NEGB: state_nx_s = ST_DIV;
            ST_DIV:  state_nx_s = last_s ? ST_FIX : ST_DIV;
            ST_FIX:  state_nx_s = ST_DONE;
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Sequencer state, working registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            f3_r     <= 3'b000;
            a_r      <= ZERO_W;
            b_r      <= ZERO_W;
            acc_r    <= ZERO_W;
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
            dvd_r    <= ZERO_W;
            dvs_r    <= ZERO_W;
            rem_r    <= ZERO_W;
            q_r      <= ZERO_W;
            cnt_r    <= 5'd0;
            result_r <= ZERO_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            own_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_DONE);
            own_r   <= owns_alu(state_nx_s);
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        f3_r     <= funct3;
                        a_r      <= rs1;
                        b_r      <= rs2;
                        acc_r    <= ZERO_W;
                        mcand_r  <= rs1;
                        mplier_r <= rs2;
                        rem_r    <= ZERO_W;
                        q_r      <= ZERO_W;
                        cnt_r    <= 5'd0;
                        err_r    <= ~legal_s;
                        if (fast_s) begin
                            result_r <= fast_res_s;
                        end
                    end
                end
                ST_MUL: begin
                    if (mplier_r[0]) begin
                        acc_r <= alu_c;
                    end
                    mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                    cnt_r    <= cnt_r + 5'd1;
                    if (last_s) begin
                        result_r <= mplier_r[0] ? alu_c : acc_r;
                    end
                end
                // NOP passes B, so alu_c is |operand| in either case.
                ST_NEGA: dvd_r <= alu_c;
                ST_NEGB: dvs_r <= alu_c;
                ST_DIV: begin
                    dvd_r <= {dvd_r[XLEN-2:0], 1'b0};
                    rem_r <= q_bit_s ? alu_c : rs_s[XLEN-1:0];
                    q_r   <= {q_r[XLEN-2:0], q_bit_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                ST_FIX:  result_r <= alu_c;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign result  = result_r;
    assign alu_own = own_r;
    assign alu_a   = alu_a_s;
    assign alu_b   = alu_b_s;
    assign alu_op  = alu_op_s;

endmodule

// File: tb/tb_alu_md_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_md_seq
// Directed bench for alu_md_seq with a behavioural model of the shared ALU.
// Cycle 1 is the clock period following the accept edge.
// -----------------------------------------------------------------------------
module tb_alu_md_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [9:0]  alu_op;
    logic [31:0] alu_c;
    logic        alu_cf;

    int checks = 0;
    int errors = 0;

    alu_md_seq #(.XLEN(32), .OPW(10)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .alu_own (alu_own),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_c   (alu_c),
        .alu_cf  (alu_cf)
    );

    // Shared ALU model: NOP passes operand B through.
    always_comb begin
        case (alu_op)
            10'h001: alu_c = alu_a + alu_b;
            10'h002: alu_c = alu_a - alu_b;
            10'h010: alu_c = {31'd0, (alu_a < alu_b)};
            default: alu_c = alu_b;
        endcase
        alu_cf = (alu_a < alu_b);
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: accept, follow it to done (bounded), then check the
    // cycle after done. pulse_cyc > 0 re-asserts start in that busy cycle.
    task automatic do_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_cyc,
                         input logic exp_err, input int pulse_cyc);
        int done_cyc;
        int own_cnt;
        int busy_cnt;
        logic err_at_done;
        done_cyc    = 0;
        own_cnt     = 0;
        busy_cnt    = 0;
        err_at_done = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == pulse_cyc) begin
                start  = 1'b1;
                funct3 = 3'b001;
            end else begin
                start  = 1'b0;
            end
            if (alu_own) own_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc    = c;
                err_at_done = err;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".err"}, {31'd0, err_at_done}, {31'd0, exp_err});
        chk({tag, ".own_cycles"}, 32'(own_cnt), 32'(exp_cyc - 1));
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
        @(posedge clk); #1;
        chk({tag, ".after_flags"}, {28'd0, done, err, busy, alu_own}, 32'd0);
        chk({tag, ".after_hold"}, result, exp_res);
    endtask

    initial begin
        bit saw_done;
        rstn   = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1    = 32'd0;
        rs2    = 32'd0;
        #1;
        chk("reset.flags", {28'd0, done, err, busy, alu_own}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.alu_op", {22'd0, alu_op}, 32'd0);
        chk("reset.alu_a", alu_a, 32'd0);
        chk("reset.alu_b", alu_b, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Multiply, with a start pulse in cycle 5 that must be ignored.
        do_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, 5);
        // Unsigned divide/remainder.
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 36, 1'b0, 0);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'h0000_0002, 36, 1'b0, 0);
        // Signed divide/remainder with sign fix-up.
        do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36, 1'b0, 0);
        do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 36, 1'b0, 0);
        do_op("div_min_2", 3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 36, 1'b0, 0);
        do_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 36, 1'b0, 0);
        // Early-out cases.
        do_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
        do_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'h0000_0005, 1, 1'b0, 0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 0);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 0);
        do_op("illegal_001", 3'b001, 32'd9, 32'd3, 32'h0000_0000, 1, 1'b1, 0);

        // Leave a non-zero result behind, then abort a divide by reset.
        do_op("divu_pre", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 36, 1'b0, 0);
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'b100;
        rs1    = 32'd100;
        rs2    = 32'd7;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort.flags", {28'd0, done, err, busy, alu_own}, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.alu_op", {22'd0, alu_op}, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort.no_done", {31'd0, saw_done}, 32'd0);
        do_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
- Multi-cycle RV32M sequencer that borrows the shared 32-bit ALU to perform MUL, DIV, DIVU, REM and REMU.
- Iterates shift-add and restoring-division steps through the ALU's ADD/SUB/pass-B operations and its unsigned-less-than flag (cf).
- Sits beside the execute stage. While alu_own is high, the core's ALU input mux selects this block's alu_a/alu_b/alu_op.
- Start/busy/done handshake with the pipeline stall logic.

Parameters:
- XLEN, 32, operand and result width and iteration count; only 32 is supported.
- OPW, 10, width of the one-hot ALU opcode.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- funct3  in  3  RV32M funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  dividend / multiplicand
- rs2  in  32  divisor / multiplier
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse; result valid
- err  out  1  high with done when funct3 is unsupported (001/010/011)
- result  out  32  held from done until the next accept
- alu_own  out  1  high while this block drives the ALU
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  10  ALU opcode
- alu_c  in  32  ALU result
- alu_cf  in  1  ALU flag: unsigned(A) < unsigned(B)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err, alu_own = 0; result=0; alu_a=alu_b=0; alu_op=NOP.
- Accept: IDLE && start → latch funct3, rs1, rs2. Cycle numbering: accept edge = cycle 0.
- start is ignored while not in IDLE. DONE → IDLE unconditionally, so the earliest next accept is the cycle after done.
- Fast path, next state DONE (done in cycle 1):
  - illegal funct3: result=0, err=1.
  - divisor==0: quotient=0xFFFFFFFF, remainder=rs1.
  - signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- MUL state (cycles 1..32), acc starts at 0:
  - if mplier[0]: ALU ADD(acc, mcand), acc<=alu_c; else op NOP and acc unchanged.
  - mcand<<=1 and mplier>>=1 internally.
  - Then DONE (cycle 33), result=acc (low 32 bits; identical for signed and unsigned operands).
- NEGA (cycle 1): signed op with rs1[31]: ALU SUB(0, rs1) → |dividend|; else NOP with B=rs1 (pass).
- NEGB (cycle 2): same treatment on rs2 → |divisor|.
- DIV state (cycles 3..34), rem 33-bit, starting at 0:
  - rs = {rem[31:0], dvd[31]}; dvd<<=1.
  - ALU SUB(rs[31:0], divisor).
  - If rs[32] || !alu_cf: rem<=alu_c, shift quotient bit 1 into q; else rem<=rs[31:0], shift 0 into q.
- FIX (cycle 35): sel = q for DIV/DIVU, rem for REM/REMU.
  - Negate sel via ALU SUB(0, sel) when DIV && sign(rs1)!=sign(rs2), or REM && rs1[31].
  - Otherwise pass sel with NOP.
- DONE (cycle 36 for divide): done=1, result registered.
- alu_own=1 exactly in MUL, NEGA, NEGB, DIV and FIX. In IDLE/DONE: alu_a=alu_b=0, alu_op=NOP.
- All ALU outputs are registered-state-decoded combinationally. alu_c/alu_cf are consumed in the same cycle; the ALU is purely combinational.
- done and err are cleared on the cycle after DONE. result holds.
- Reset mid-operation aborts with no done pulse.

Decomposition:
- Package alu_md_pkg:
  - ALU opcode constants: NOP 10'h000, ADD 10'h001, SUB 10'h002, SLTU 10'h010.
  - funct3 constants.
  - State enum: IDLE, MUL, NEGA, NEGB, DIV, FIX, DONE.
  - Iteration count 32.
- No sub-module. A 5-bit iteration counter lives in the sequencer.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → result=0xFFFFFFEB, done at cycle 33, alu_own high cycles 1..32, busy high cycles 1..33.
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; done at cycle 36.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIV 0x80000000/2 → 0xC0000000.
- Special cases, each with done at cycle 1 and alu_own never high:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- funct3=001 → done and err at cycle 1, result=0; start pulsed at cycle 5 of a MUL is ignored and the MUL result is unaffected.
- rstn low at cycle 10 of a DIV → immediate IDLE, busy=0, alu_own=0, result=0, no done. Then MUL 3*4 → 12 at cycle 33.
